main_fsm: RTL and testbench

Multicycle main control FSM that sits directly upstream of the ALU decoder. It sequences each RISC-V instruction through fetch/decode/execute/memory/writeback steps, and drives the datapath enables, the mux selects and aluOp into aluDecoder. It supports lw, sw, R-type, I-type ALU, beq and jal. Memory is variable-latency, gated by a memReady handshake. It also keeps a retired-instruction counter.

---
 rtl/main_fsm_pkg.sv | 63 ++++++
 rtl/main_fsm_outdec.sv | 78 +++++++
 rtl/main_fsm.sv | 106 ++++++++++
 tb/tb_main_fsm.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/main_fsm_pkg.sv
// Shared types and encodings for the multicycle main control FSM.
// The optional illegal-opcode trap is enabled with MAIN_FSM_ILLEGAL_TRAP_EN.
package main_fsm_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECUTER,
        EXECUTEI,
        ALUWB,
        BEQ,
        JAL,
        ERROR
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    typedef struct packed {
        logic [1:0] alu_op;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       adr_src;
        logic       ir_write;
        logic       pc_update;
        logic       branch;
        logic       reg_write;
        logic       mem_write;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    // True on the cycle whose clock edge completes an instruction.
    function automatic logic retires(state_t s, logic mem_ready);
        return (s == MEMWB) || (s == MEMWRITE && mem_ready) || (s == ALUWB) || (s == BEQ);
    endfunction

endpackage

// File: rtl/main_fsm_outdec.sv
// Combinational state-to-control-word decoder; memReady only gates the
// instruction fetch enables.
module main_fsm_outdec
    import main_fsm_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = CTRL_IDLE;
        unique case (state)
            FETCH: begin
                ctrl.adr_src    = 1'b0;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALURESULT;
                ctrl.ir_write   = mem_ready;
                ctrl.pc_update  = mem_ready;
            end
            DECODE: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEMADR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEMREAD: begin
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RES_ALUOUT;
            end
            MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_write  = 1'b1;
            end
            MEMWRITE: begin
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RES_ALUOUT;
                ctrl.mem_write  = 1'b1;
            end
            EXECUTER: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            EXECUTEI: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
            end
            BEQ: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.result_src = RES_ALUOUT;
                ctrl.branch     = 1'b1;
            end
            JAL: begin
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_update  = 1'b1;
            end
            default: ctrl = CTRL_IDLE;
        endcase
    end

endmodule

// File: rtl/main_fsm.sv
// Multicycle RISC-V main control FSM with retired-instruction counter.
// Define MAIN_FSM_ILLEGAL_TRAP_EN to trap unknown opcodes in ERROR and expose illegalOp.
module main_fsm
    import main_fsm_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic             memReady,
    output logic [1:0]       aluOp,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCUpdate,
    output logic             Branch,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [CNT_W-1:0] instret
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    ,
    output logic             illegalOp
`endif
);

`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    localparam state_t ILLEGAL_NEXT = ERROR;
`else
    localparam state_t ILLEGAL_NEXT = FETCH;
`endif

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] instret_reg;
    ctrl_t            ctrl_dec, ctrl;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= FETCH;
            instret_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (retires(state_reg, memReady))
                instret_reg <= instret_reg + CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            FETCH:    if (memReady) state_next = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_R:         state_next = EXECUTER;
                    OP_I:         state_next = EXECUTEI;
                    OP_BEQ:       state_next = BEQ;
                    OP_JAL:       state_next = JAL;
                    default:      state_next = ILLEGAL_NEXT;
                endcase
            end
            MEMADR:   state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  if (memReady) state_next = MEMWB;
            MEMWB:    state_next = FETCH;
            MEMWRITE: if (memReady) state_next = FETCH;
            EXECUTER: state_next = ALUWB;
            EXECUTEI: state_next = ALUWB;
            ALUWB:    state_next = FETCH;
            BEQ:      state_next = FETCH;
            JAL:      state_next = ALUWB;
            ERROR:    state_next = ILLEGAL_NEXT;
            default:  state_next = FETCH;
        endcase
    end

    main_fsm_outdec u_outdec (
        .state     (state_reg),
        .mem_ready (memReady),
        .ctrl      (ctrl_dec)
    );

    // Reset is synchronous, so the state may still be mid-instruction in the
    // reset cycle; force the whole control word quiet here.
    always_comb begin
        ctrl = reset ? CTRL_IDLE : ctrl_dec;
    end

    assign aluOp     = ctrl.alu_op;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign ResultSrc = ctrl.result_src;
    assign AdrSrc    = ctrl.adr_src;
    assign IRWrite   = ctrl.ir_write;
    assign PCUpdate  = ctrl.pc_update;
    assign Branch    = ctrl.branch;
    assign RegWrite  = ctrl.reg_write;
    assign MemWrite  = ctrl.mem_write;
    assign instret   = instret_reg;

`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    assign illegalOp = !reset && (state_reg == ERROR);
`endif

endmodule

// File: tb/tb_main_fsm.sv
// Self-checking bench for main_fsm: directed per-cycle vector table, then
// randomized instructions checked against an instruction-level model.
module tb_main_fsm;

    localparam logic [6:0] T_LW  = 7'b0000011;
    localparam logic [6:0] T_SW  = 7'b0100011;
    localparam logic [6:0] T_R   = 7'b0110011;
    localparam logic [6:0] T_I   = 7'b0010011;
    localparam logic [6:0] T_BEQ = 7'b1100011;
    localparam logic [6:0] T_JAL = 7'b1101111;
    localparam logic [6:0] T_BAD = 7'b1111111;

    // {aluOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite}
    localparam logic [13:0] C_RST     = 14'b0;
    localparam logic [13:0] C_FETCH_W = {2'b00, 2'b00, 2'b10, 2'b10, 6'b000000};
    localparam logic [13:0] C_FETCH   = {2'b00, 2'b00, 2'b10, 2'b10, 6'b011000};
    localparam logic [13:0] C_DECODE  = {2'b00, 2'b01, 2'b01, 2'b00, 6'b000000};
    localparam logic [13:0] C_MEMADR  = {2'b00, 2'b10, 2'b01, 2'b00, 6'b000000};
    localparam logic [13:0] C_MEMREAD = {2'b00, 2'b00, 2'b00, 2'b00, 6'b100000};
    localparam logic [13:0] C_MEMWB   = {2'b00, 2'b00, 2'b00, 2'b01, 6'b000010};
    localparam logic [13:0] C_MEMWR   = {2'b00, 2'b00, 2'b00, 2'b00, 6'b100001};
    localparam logic [13:0] C_EXR     = {2'b10, 2'b10, 2'b00, 2'b00, 6'b000000};
    localparam logic [13:0] C_EXI     = {2'b10, 2'b10, 2'b01, 2'b00, 6'b000000};
    localparam logic [13:0] C_ALUWB   = {2'b00, 2'b00, 2'b00, 2'b00, 6'b000010};
    localparam logic [13:0] C_BEQ     = {2'b01, 2'b10, 2'b00, 2'b00, 6'b000100};
    localparam logic [13:0] C_JAL     = {2'b00, 2'b01, 2'b10, 2'b00, 6'b001000};

    logic        clk = 1'b0;
    logic        reset, memReady;
    logic [6:0]  op;
    logic [1:0]  aluOp, ALUSrcA, ALUSrcB, ResultSrc;
    logic        AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite;
    logic [31:0] instret;
    logic [1:0]  aluOp_w, ALUSrcA_w, ALUSrcB_w, ResultSrc_w;
    logic        AdrSrc_w, IRWrite_w, PCUpdate_w, Branch_w, RegWrite_w, MemWrite_w;
    logic [3:0]  instret_w;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    logic        illegalOp, illegalOp_w;
`endif

    logic [13:0] got_ctrl;
    assign got_ctrl = {aluOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite};

    always #5 clk = ~clk;

    main_fsm dut (
        .clk(clk), .reset(reset), .op(op), .memReady(memReady),
        .aluOp(aluOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCUpdate(PCUpdate), .Branch(Branch),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .instret(instret)
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
        , .illegalOp(illegalOp)
`endif
    );

    main_fsm #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .op(op), .memReady(memReady),
        .aluOp(aluOp_w), .ALUSrcA(ALUSrcA_w), .ALUSrcB(ALUSrcB_w), .ResultSrc(ResultSrc_w),
        .AdrSrc(AdrSrc_w), .IRWrite(IRWrite_w), .PCUpdate(PCUpdate_w), .Branch(Branch_w),
        .RegWrite(RegWrite_w), .MemWrite(MemWrite_w), .instret(instret_w)
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
        , .illegalOp(illegalOp_w)
`endif
    );

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic        mr;
        logic [13:0] ctrl;
        int unsigned cnt;
        string       name;
    } vec_t;

    vec_t        tbl[$];
    int          vectors    = 0;
    int          miscompares = 0;
    int unsigned model_cnt  = 0;

    function automatic void add(logic rst, logic [6:0] o, logic mr, logic [13:0] c,
                                int unsigned n, string name);
        vec_t v;
        v.rst = rst; v.op = o; v.mr = mr; v.ctrl = c; v.cnt = n; v.name = name;
        tbl.push_back(v);
    endfunction

    task automatic chk(string name, logic [13:0] exp_ctrl, int unsigned exp_cnt);
        vectors++;
        if (got_ctrl !== exp_ctrl || instret !== exp_cnt) begin
            miscompares++;
            $display("FAIL %s: got ctrl=%b instret=%0d, required ctrl=%b instret=%0d",
                     name, got_ctrl, instret, exp_ctrl, exp_cnt);
        end else
            $display("vec %-12s ctrl=%b instret=%0d ok", name, got_ctrl, instret);
    endtask

    task automatic do_reset();
        reset = 1'b1; memReady = 1'b0; op = 7'h00;
        @(negedge clk);
        chk("reset", C_RST, instret);
        @(posedge clk); #1;
        reset = 1'b0;
        model_cnt = 0;
    endtask

    // One instruction: kind 0 lw,1 sw,2 R,3 I,4 beq,5 jal,6 illegal.
    // fw = fetch wait cycles, mw = data memory wait cycles.
    task automatic do_instr(input int kind, input int fw, input int mw);
        logic [6:0] opc;
        int lat, total;
        logic is_mem;
        int n_irw, n_pcu, n_rw, n_br, n_mw;
        int e_pcu, e_rw, e_br, e_mw;
        n_irw = 0; n_pcu = 0; n_rw = 0; n_br = 0; n_mw = 0;
        case (kind)
            0: begin opc = T_LW;  lat = 5; end
            1: begin opc = T_SW;  lat = 4; end
            2: begin opc = T_R;   lat = 4; end
            3: begin opc = T_I;   lat = 4; end
            4: begin opc = T_BEQ; lat = 3; end
            5: begin opc = T_JAL; lat = 4; end
            default: begin opc = T_BAD; lat = 2; end
        endcase
        is_mem = (kind <= 1);
        total  = lat + fw + (is_mem ? mw : 0);
        for (int k = 0; k < total; k++) begin
            reset = 1'b0;
            op = (k == fw + 1 || k == fw + 2) ? opc : 7'($urandom);
            if (k < fw)                       memReady = 1'b0;
            else if (k == fw)                 memReady = 1'b1;
            else if (is_mem && k >= fw + 3)   memReady = (k >= fw + 3 + mw);
            else                              memReady = 1'($urandom);
            @(negedge clk);
            n_irw += int'(IRWrite); n_pcu += int'(PCUpdate); n_rw += int'(RegWrite);
            n_br  += int'(Branch);  n_mw  += int'(MemWrite);
            @(posedge clk); #1;
        end
        if (kind <= 5) model_cnt++;
        e_pcu = (kind == 5) ? 2 : 1;
        e_rw  = (kind == 0 || kind == 2 || kind == 3 || kind == 5) ? 1 : 0;
        e_br  = (kind == 4) ? 1 : 0;
        e_mw  = (kind == 1) ? mw + 1 : 0;
        vectors++;
        if (n_irw != 1 || n_pcu != e_pcu || n_rw != e_rw || n_br != e_br || n_mw != e_mw ||
            instret !== model_cnt || instret_w !== 4'(model_cnt)) begin
            miscompares++;
            $display("FAIL instr kind=%0d fw=%0d mw=%0d: got irw/pcu/rw/br/mw=%0d/%0d/%0d/%0d/%0d instret=%0d/%0d, required 1/%0d/%0d/%0d/%0d instret=%0d/%0d",
                     kind, fw, mw, n_irw, n_pcu, n_rw, n_br, n_mw, instret, instret_w,
                     e_pcu, e_rw, e_br, e_mw, model_cnt, model_cnt % 16);
        end else
            $display("instr kind=%0d fw=%0d mw=%0d cycles=%0d instret=%0d ok", kind, fw, mw, total, instret);
    endtask

    initial begin
        reset = 1'b1; op = 7'h00; memReady = 1'b0;
        @(posedge clk); #1;

        add(1, 7'h00, 1, C_RST, 0, "rst0");
        add(1, T_R,   1, C_RST, 0, "rst1");
        add(0, 7'h7f, 1, C_FETCH,   0, "R.fetch");
        add(0, T_R,   1, C_DECODE,  0, "R.decode");
        add(0, 7'h00, 1, C_EXR,     0, "R.exec");
        add(0, 7'h23, 1, C_ALUWB,   0, "R.wb");
        add(0, 7'h00, 1, C_FETCH,   1, "lw.fetch");
        add(0, T_LW,  1, C_DECODE,  1, "lw.decode");
        add(0, T_LW,  1, C_MEMADR,  1, "lw.adr");
        add(0, T_SW,  1, C_MEMREAD, 1, "lw.read");
        add(0, 7'h00, 1, C_MEMWB,   1, "lw.wb");
        add(0, 7'h00, 1, C_FETCH,   2, "sw.fetch");
        add(0, T_SW,  1, C_DECODE,  2, "sw.decode");
        add(0, T_SW,  1, C_MEMADR,  2, "sw.adr");
        add(0, T_LW,  0, C_MEMWR,   2, "sw.wr0");
        add(0, 7'h00, 0, C_MEMWR,   2, "sw.wr1");
        add(0, 7'h00, 0, C_MEMWR,   2, "sw.wr2");
        add(0, 7'h00, 1, C_MEMWR,   2, "sw.wr3");
        add(0, 7'h00, 1, C_FETCH,   3, "beq.fetch");
        add(0, T_BEQ, 1, C_DECODE,  3, "beq.decode");
        add(0, T_R,   0, C_BEQ,     3, "beq.exec");
        add(0, 7'h00, 1, C_FETCH,   4, "jal.fetch");
        add(0, T_JAL, 1, C_DECODE,  4, "jal.decode");
        add(0, T_LW,  0, C_JAL,     4, "jal.exec");
        add(0, 7'h00, 0, C_ALUWB,   4, "jal.wb");
        add(0, 7'h00, 0, C_FETCH_W, 5, "I.fwait");
        add(0, 7'h00, 1, C_FETCH,   5, "I.fetch");
        add(0, T_I,   1, C_DECODE,  5, "I.decode");
        add(0, 7'h00, 1, C_EXI,     5, "I.exec");
        add(0, 7'h00, 1, C_ALUWB,   5, "I.wb");
`ifndef MAIN_FSM_ILLEGAL_TRAP_EN
        add(0, 7'h00, 1, C_FETCH,   6, "bad.fetch");
        add(0, T_BAD, 1, C_DECODE,  6, "bad.decode");
`endif
        add(0, 7'h00, 1, C_FETCH,   6, "abort.fetch");
        add(0, T_R,   1, C_DECODE,  6, "abort.dec");
        add(1, 7'h00, 1, C_RST,     6, "abort.rst");
        add(0, 7'h00, 0, C_FETCH_W, 0, "abort.after");

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst; op = tbl[i].op; memReady = tbl[i].mr;
            @(negedge clk);
            chk(tbl[i].name, tbl[i].ctrl, tbl[i].cnt);
            @(posedge clk); #1;
        end

`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
        reset = 1'b0; op = 7'h11; memReady = 1'b1;
        @(negedge clk); chk("trap.fetch", C_FETCH, 0);
        @(posedge clk); #1;
        op = T_BAD;
        @(negedge clk); chk("trap.decode", C_DECODE, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            op = T_R; memReady = 1'($urandom);
            @(negedge clk);
            chk("trap.error", C_RST, 0);
            vectors++;
            if (illegalOp !== 1'b1) begin
                miscompares++;
                $display("FAIL trap.illegalOp: got %b, required 1", illegalOp);
            end
            @(posedge clk); #1;
        end
`endif

        do_reset();
        for (int i = 0; i < 40; i++) begin
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
            do_instr($urandom_range(0, 5), $urandom_range(0, 2), $urandom_range(0, 3));
`else
            do_instr($urandom_range(0, 6), $urandom_range(0, 2), $urandom_range(0, 3));
`endif
        end

        do_reset();
        for (int i = 0; i < 16; i++) begin
            do_instr(2, 0, 0);
            if (i == 14) begin
                vectors++;
                if (instret_w !== 4'd15) begin
                    miscompares++;
                    $display("FAIL wrap.15: got %0d, required 15", instret_w);
                end
            end
        end
        vectors++;
        if (instret_w !== 4'd0 || instret !== 32'd16) begin
            miscompares++;
            $display("FAIL wrap.0: got %0d/%0d, required 0/16", instret_w, instret);
        end else
            $display("wrap instret4=%0d instret32=%0d ok", instret_w, instret);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
